// File: rtl/ps2_host_command_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ack check.
// Optional `define PS2_TX_TIMEOUT_EN adds a watchdog on device clock activity (TIMEOUT_CYCLES).
module ps2_host_command_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       cmd_done,
    output logic       cmd_error
);

    localparam int               INH_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        TX,
        WAIT_ACK,
        WAIT_IDLE,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    logic [INH_W-1:0] inh_cnt;
    logic [3:0]       edge_cnt;
    logic [7:0]       tx_byte;
    logic             tx_parity;

    logic clk_meta, clk_sync, clk_prev;
    logic dat_meta, dat_sync;
    logic ps2_fall;
    logic to_hit;

    // Line synchronizers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk_in;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat_in;
            dat_sync <= dat_meta;
        end
    end

    assign ps2_fall = clk_prev & ~clk_sync;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    // Held at zero outside the watched states, so entering any of them starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || ps2_fall || !(state inside {TX, WAIT_ACK, WAIT_IDLE})) begin
            to_cnt <= '0;
        end else if (!to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (to_cnt == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            cmd_done   <= 1'b0;
            cmd_error  <= 1'b0;
            inh_cnt    <= '0;
            edge_cnt   <= '0;
            tx_byte    <= '0;
            tx_parity  <= 1'b0;
        end else begin
            cmd_done  <= 1'b0;
            cmd_error <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready  <= 1'b1;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (cmd_valid) begin
                        tx_byte    <= cmd_data;
                        tx_parity  <= ~^cmd_data;
                        inh_cnt    <= '0;
                        cmd_ready  <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                RTS: begin
                    // Releasing the clock with data held low is the request-to-send.
                    ps2_clk_oe <= 1'b0;
                    edge_cnt   <= '0;
                    state      <= TX;
                end
                TX: begin
                    if (ps2_fall) begin
                        edge_cnt <= edge_cnt + 1'b1;
                        if (edge_cnt < 4'd8) begin
                            ps2_dat_oe <= ~tx_byte[edge_cnt[2:0]];
                        end else if (edge_cnt == 4'd8) begin
                            ps2_dat_oe <= ~tx_parity;
                        end else begin
                            ps2_dat_oe <= 1'b0;
                            state      <= WAIT_ACK;
                        end
                    end else if (to_hit) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        cmd_error  <= 1'b1;
                        state      <= ERROR;
                    end
                end
                WAIT_ACK: begin
                    if (ps2_fall) begin
                        if (dat_sync) begin
                            cmd_error <= 1'b1;
                            state     <= ERROR;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else if (to_hit) begin
                        cmd_error <= 1'b1;
                        state     <= ERROR;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync && dat_sync) begin
                        cmd_done <= 1'b1;
                        state    <= DONE;
                    end else if (to_hit) begin
                        cmd_error <= 1'b1;
                        state     <= ERROR;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                ERROR: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    cmd_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    cmd_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_command_tx.sv
// Self-checking bench for ps2_host_command_tx: open-collector device model plus a
// per-cycle timeline model of the expected host outputs.
module tb_ps2_host_command_tx;

    localparam int INH  = 5000;
    localparam int TO   = 1000;
    localparam int HALF = 20;
    localparam int BIG  = 1000000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, cmd_done, cmd_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_line, ps2_dat_line;

    assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_command_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .ps2_clk_in(ps2_clk_line),
        .ps2_dat_in(ps2_dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .cmd_done  (cmd_done),
        .cmd_error (cmd_error)
    );

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;
    bit chk_en = 1'b0;

    // Transaction timeline: tags are negedge counts at the moment the bench drove an input.
    bit         txn_on = 1'b0;
    int         acc_tag = 0;
    int         kill_tag = BIG;
    int         rel_tag = BIG;
    int         edge_tag [1:11];
    logic [7:0] m_byte = 8'h00;
    bit         m_ack = 1'b0;
    bit         m_to = 1'b0;

    int done_cnt = 0;
    int err_cnt = 0;
    int inh_seen = 0;
    int err_c = 0;
    logic [10:0] frame;

    // Outputs {ready, clk_oe, dat_oe, done, error}; line changes reach outputs 4 samples later
    // (two synchronizer flops, edge detect, registered output).
    function automatic logic [4:0] expectOut(input int c);
        int   n;
        int   ones;
        int   end_c;
        logic level;
        if (!txn_on || c <= acc_tag + 1 || c >= kill_tag + 2) return 5'b10000;
        if (m_ack)     end_c = rel_tag + 4;
        else if (m_to) end_c = edge_tag[4] + 4 + TO;
        else           end_c = edge_tag[11] + 4;
        if (c > end_c) return 5'b10000;
        if (c == end_c) return m_ack ? 5'b00010 : 5'b00001;
        if (c <= acc_tag + 1 + INH) return 5'b01000;
        if (c == acc_tag + 2 + INH) return 5'b01100;
        n = 0;
        for (int i = 1; i <= 10; i++) if (edge_tag[i] + 4 <= c) n++;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(m_byte[i]);
        if (n == 0)      level = 1'b0;
        else if (n <= 8) level = m_byte[n-1];
        else if (n == 9) level = ((ones % 2) == 0);
        else             level = 1'b1;
        return {2'b00, ~level, 2'b00};
    endfunction

    always @(negedge clk) begin : cmp_proc
        logic [4:0] exp_v;
        logic [4:0] act_v;
        ncyc = ncyc + 1;
        if (chk_en) begin
            act_v = {cmd_ready, ps2_clk_oe, ps2_dat_oe, cmd_done, cmd_error};
            exp_v = expectOut(ncyc);
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("[TB] FAIL cycle_model c=%0d {rdy,clk_oe,dat_oe,done,err}: got %b required %b",
                         ncyc, act_v, exp_v);
            end
            if (cmd_done === 1'b1) done_cnt++;
            if (cmd_error === 1'b1) begin
                err_cnt++;
                err_c = ncyc;
            end
            if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) inh_seen++;
        end
    end

    task automatic stepCycles(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit ack, input bit to);
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 100) begin
            stepCycles(1);
            guard++;
        end
        checkOutput("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        for (int i = 1; i <= 11; i++) edge_tag[i] = BIG;
        rel_tag  = BIG;
        kill_tag = BIG;
        m_byte   = b;
        m_ack    = ack;
        m_to     = to;
        acc_tag  = ncyc;
        txn_on   = 1'b1;
        done_cnt = 0;
        err_cnt  = 0;
        inh_seen = 0;
        err_c    = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        stepCycles(1);
        cmd_valid = 1'b0;
        cmd_data  = ~b;
    endtask

    // Device side: waits for request-to-send, clocks nedges falls, samples the line while low.
    task automatic deviceRun(input int nedges, input bit do_ack, output logic [10:0] fr);
        int guard;
        fr = '0;
        guard = 0;
        while (ps2_clk_oe !== 1'b1 && guard < 50) begin
            stepCycles(1);
            guard++;
        end
        guard = 0;
        while (ps2_clk_oe !== 1'b0 && guard < INH + 50) begin
            stepCycles(1);
            guard++;
        end
        if (ps2_clk_oe !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rts_wait: clk_oe got %b required 0", ps2_clk_oe);
            return;
        end
        fr[0] = ps2_dat_line;
        stepCycles(HALF);
        for (int i = 1; i <= nedges && i <= 10; i++) begin
            dev_clk_low = 1'b1;
            edge_tag[i] = ncyc;
            stepCycles(HALF);
            fr[i] = ps2_dat_line;
            dev_clk_low = 1'b0;
            stepCycles(HALF);
        end
        if (nedges >= 11) begin
            if (do_ack) dev_dat_low = 1'b1;
            stepCycles(5);
            dev_clk_low  = 1'b1;
            edge_tag[11] = ncyc;
            stepCycles(HALF);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            rel_tag     = ncyc;
            stepCycles(HALF);
        end
    endtask

    task automatic runCmd(input string name, input logic [7:0] b, input logic [10:0] want);
        applyStimulus(b, 1'b1, 1'b0);
        deviceRun(11, 1'b1, frame);
        stepCycles(5);
        checkOutput({name, "_frame"}, {21'd0, frame}, {21'd0, want});
        checkOutput({name, "_done_pulses"}, done_cnt, 32'd1);
        checkOutput({name, "_error_pulses"}, err_cnt, 32'd0);
    endtask

    initial begin
        stepCycles(2);
        checkOutput("reset_state", {27'd0, cmd_ready, ps2_clk_oe, ps2_dat_oe, cmd_done, cmd_error},
                    32'b10000);
        reset  = 1'b0;
        chk_en = 1'b1;
        stepCycles(5);

        $display("[TB] command 0xED");
        runCmd("cmd_ed", 8'hED, {1'b1, 1'b1, 8'hED, 1'b0});
        checkOutput("cmd_ed_inhibit_cycles", inh_seen, 32'd5000);

        $display("[TB] command 0xF4");
        runCmd("cmd_f4", 8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0});

        $display("[TB] command 0x00");
        runCmd("cmd_00", 8'h00, {1'b1, 1'b1, 8'h00, 1'b0});

        $display("[TB] command 0xAB without ack");
        applyStimulus(8'hAB, 1'b0, 1'b0);
        deviceRun(11, 1'b0, frame);
        checkOutput("nack_error_pulses", err_cnt, 32'd1);
        checkOutput("nack_done_pulses", done_cnt, 32'd0);
        checkOutput("nack_error_latency", err_c - edge_tag[11], 32'd4);
        checkOutput("nack_ready_after", {31'd0, cmd_ready}, 32'd1);

        $display("[TB] device clock pulse while idle");
        dev_clk_low = 1'b1;
        stepCycles(10);
        dev_clk_low = 1'b0;
        stepCycles(10);
        checkOutput("idle_edge_ignored", {27'd0, cmd_ready, ps2_clk_oe, ps2_dat_oe, cmd_done, cmd_error},
                    32'b10000);

        $display("[TB] reset at edge 6");
        applyStimulus(8'h12, 1'b1, 1'b0);
        deviceRun(5, 1'b0, frame);
        dev_clk_low = 1'b1;
        edge_tag[6] = ncyc;
        reset       = 1'b1;
        kill_tag    = ncyc;
        stepCycles(3);
        dev_clk_low = 1'b0;
        stepCycles(2);
        reset = 1'b0;
        stepCycles(10);
        checkOutput("reset_done_pulses", done_cnt, 32'd0);
        checkOutput("reset_error_pulses", err_cnt, 32'd0);

        $display("[TB] command 0xFF after reset");
        runCmd("cmd_ff", 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0});

        $display("[TB] command 0x3C with cmd_valid toggling during transfer");
        applyStimulus(8'h3C, 1'b1, 1'b0);
        fork
            deviceRun(11, 1'b1, frame);
            begin
                stepCycles(INH + 100);
                for (int k = 0; k < 6; k++) begin
                    cmd_valid = ~cmd_valid;
                    cmd_data  = 8'h55;
                    stepCycles(7);
                end
                cmd_valid = 1'b0;
            end
        join
        stepCycles(5);
        checkOutput("toggle_frame", {21'd0, frame}, {21'd0, 1'b1, 1'b1, 8'h3C, 1'b0});
        checkOutput("toggle_done_pulses", done_cnt, 32'd1);

`ifdef PS2_TX_TIMEOUT_EN
        $display("[TB] device stops clocking after edge 4");
        applyStimulus(8'hA5, 1'b0, 1'b1);
        deviceRun(4, 1'b0, frame);
        stepCycles(TO + 20);
        checkOutput("timeout_error_pulses", err_cnt, 32'd1);
        checkOutput("timeout_done_pulses", done_cnt, 32'd0);
        checkOutput("timeout_latency", err_c - edge_tag[4], 32'd1004);
`endif

        stepCycles(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
